wb_ddr2_port_arbiter: RTL
=========================

Name: wb_ddr2_port_arbiter

Overview:
- Parametrised N-to-1 Wishbone B3 arbiter.
- Sits in front of one DDR2 controller Wishbone slave port when the system has more masters than the controller has ports.
- Round-robin grant; the grant is held for the whole cycle (cyc), so incrementing and wrap bursts (cti/bte) are never split.
- Bus watchdog: a stalled access ends with err; err and rty are driven per master instead of being tied low.

Parameters:
- NUM_MASTERS, 4, number of master channels (2..8).
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT_CYCLES, 1023, wb_clk cycles of stb without ack/err before the arbiter terminates the access with err; 0 disables the watchdog.

Ports:
- wb_clk  in  1  bus clock
- wb_rst  in  1  reset
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses, master n at [n*AW +: AW]
- wbm_bte_i  in  NUM_MASTERS*2  burst type
- wbm_cti_i  in  NUM_MASTERS*3  cycle type
- wbm_cyc_i  in  NUM_MASTERS  cycle
- wbm_stb_i  in  NUM_MASTERS  strobe
- wbm_we_i  in  NUM_MASTERS  write enable
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
- wbm_dat_i  in  NUM_MASTERS*DW  write data
- wbm_dat_o  out  DW  read data, shared by all masters
- wbm_ack_o  out  NUM_MASTERS  per-master ack
- wbm_err_o  out  NUM_MASTERS  per-master err
- wbm_rty_o  out  NUM_MASTERS  per-master rty; constant 0
- wbs_adr_o, wbs_bte_o, wbs_cti_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_dat_o  out  AW/2/3/1/1/1/DW/8/DW  to the DDR2 port
- wbs_dat_i  in  DW  read data from the DDR2 port
- wbs_ack_i  in  1  ack from the DDR2 port
- wbs_err_i  in  1  err from the DDR2 port
- grant_o  out  NUM_MASTERS  one-hot current owner, all-zero when idle

Behaviour:
- One clock, wb_clk. wb_rst is asynchronous and active-high.
- Reset values: state IDLE, grant_o 0, last-grant pointer = NUM_MASTERS-1 (so master 0 wins first), watchdog counter 0, wbs_cyc_o 0, wbs_stb_o 0, all wbm_ack_o/err_o/rty_o 0.
- State machine: IDLE, OWN.
- IDLE, any wbm_cyc_i high:
  - Select the first requesting master scanning upward from last+1 with modulo wrap.
  - Register the grant on the next edge; go to OWN and update last.
  - Arbitration latency is exactly 1 cycle from cyc to the slave seeing wbs_cyc_o.
- OWN:
  - wbs_* outputs are combinational copies of the granted master's signals.
  - wbs_ack_i and wbs_err_i route only to the granted master.
  - wbm_dat_o = wbs_dat_i.
- OWN, granted master drops cyc:
  - Next edge returns to IDLE and clears grant_o.
  - wbs_cyc_o and wbs_stb_o are forced 0 in the release cycle.
  - Minimum one idle cycle between owners; a master re-requesting immediately still waits one round-robin pass.
- Non-granted masters get ack/err/rty 0 and are ignored; their cyc may rise or fall freely.
- Slave outputs in IDLE: all wbs_* driven 0.
- Watchdog:
  - Counts up while in OWN with wbs_stb_o=1 and wbs_ack_i=0 and wbs_err_i=0.
  - Clears on ack, err, stb low, or leaving OWN.
  - When the count reaches TIMEOUT_CYCLES: pulse err to the granted master for exactly 1 cycle, force wbs_stb_o and wbs_cyc_o 0 in that cycle, clear the counter.
  - The master then either drops cyc (normal release) or retries with stb.
- Simultaneous slave ack and watchdog expiry: ack wins, no err.
- wbs_ack_i or wbs_err_i arriving in IDLE: discarded.
- Reset mid-burst: grant and outputs return to reset values immediately; no ack/err is produced.

Test Plan:
- Reset, then masters 0 and 2 raise cyc/stb in the same cycle -> grant_o=4'b0001 one cycle later. When m0 drops cyc: one idle cycle, then grant_o=4'b0100.
- All 4 masters request continuously with single accesses, each dropping cyc after its ack -> grant order 0,1,2,3,0; no master starved; each ack seen only on the owner's bit.
- m1 does an 8-beat incrementing burst (cti=010, last beat cti=111) while m3 requests -> all 8 acks go to m1 with no gap in ownership; m3 granted only after m1 drops cyc.
- TIMEOUT_CYCLES=16, slave never acks -> wbm_err_o[granted] high for 1 cycle exactly 16 cycles after stb was first seen on the slave side; wbs_stb_o low in that cycle; wbm_ack_o stays 0.
- Slave asserts wbs_err_i on a write from m2 -> wbm_err_o[2]=1 for that cycle, the other err bits 0, wbm_rty_o always 0.
- Assert wb_rst during an m0 burst with 3 of 8 beats done -> grant_o=0, wbs_cyc_o=0 asynchronously. After release, m1 requesting wins first (pointer reset).

Source files
------------

// File: rtl/wb_ddr2_port_arbiter.sv
// Round-robin N-to-1 Wishbone B3 arbiter for one DDR2 controller port.
// Ownership lasts for the whole cyc; a watchdog ends stalled accesses with err.
module wb_ddr2_port_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [1:0]                  wbs_bte_o,
  output logic [2:0]                  wbs_cti_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic [DW-1:0]               wbs_dat_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                 r_state;
  logic [PW-1:0]          r_last;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [CW-1:0]          r_wdCnt;

  logic          w_found;
  logic [PW-1:0] w_next;
  logic          w_mCyc, w_mStb, w_mWe;
  logic [AW-1:0] w_mAdr;
  logic [1:0]    w_mBte;
  logic [2:0]    w_mCti;
  logic [SW-1:0] w_mSel;
  logic [DW-1:0] w_mDat;
  logic          w_own, w_active, w_expire, w_count;

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_next  = r_last;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!w_found && wbm_cyc_i[(int'(r_last) + i) % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_next  = PW'((int'(r_last) + i) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    w_mCyc = 1'b0;
    w_mStb = 1'b0;
    w_mWe  = 1'b0;
    w_mAdr = '0;
    w_mBte = '0;
    w_mCti = '0;
    w_mSel = '0;
    w_mDat = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (r_last == PW'(m)) begin
        w_mCyc = wbm_cyc_i[m];
        w_mStb = wbm_stb_i[m];
        w_mWe  = wbm_we_i[m];
        w_mAdr = wbm_adr_i[m*AW +: AW];
        w_mBte = wbm_bte_i[m*2 +: 2];
        w_mCti = wbm_cti_i[m*3 +: 3];
        w_mSel = wbm_sel_i[m*SW +: SW];
        w_mDat = wbm_dat_i[m*DW +: DW];
      end
    end
  end

  assign w_own    = (r_state == S_OWN);
  assign w_active = w_own && w_mCyc;
  // A slave ack in the expiry cycle takes precedence over the watchdog.
  assign w_expire = (TIMEOUT_CYCLES != 0) && w_active && w_mStb && !wbs_ack_i &&
                    !wbs_err_i && (r_wdCnt == CW'(TIMEOUT_CYCLES));
  assign w_count  = (TIMEOUT_CYCLES != 0) && w_active && w_mStb && !wbs_ack_i &&
                    !wbs_err_i && !w_expire;

  assign wbs_cyc_o = w_active && !w_expire;
  assign wbs_stb_o = w_active && w_mStb && !w_expire;
  assign wbs_we_o  = w_own ? w_mWe  : 1'b0;
  assign wbs_adr_o = w_own ? w_mAdr : '0;
  assign wbs_bte_o = w_own ? w_mBte : '0;
  assign wbs_cti_o = w_own ? w_mCti : '0;
  assign wbs_sel_o = w_own ? w_mSel : '0;
  assign wbs_dat_o = w_own ? w_mDat : '0;

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = (w_own && wbs_ack_i) ? r_grant : '0;
  assign wbm_err_o = (w_own && (wbs_err_i || w_expire)) ? r_grant : '0;
  assign wbm_rty_o = '0;
  assign grant_o   = r_grant;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= PW'(NUM_MASTERS - 1);
      r_wdCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdCnt <= '0;
          if (w_found) begin
            r_state <= S_OWN;
            r_grant <= NUM_MASTERS'(1) << w_next;
            r_last  <= w_next;
          end
        end
        S_OWN: begin
          if (!w_mCyc) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_wdCnt <= '0;
          end else if (w_count) begin
            r_wdCnt <= r_wdCnt + 1'b1;
          end else begin
            r_wdCnt <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_wdCnt <= '0;
        end
      endcase
    end
  end

endmodule
